addr_fifo_reader: RTL and testbench

Read side of the address FIFO. The driver register block pushes host-written address words into this FIFO. This block pops those words and turns each one into one address, or a burst of consecutive addresses when consecutive mode is enabled. It presents them on a valid/ready stream to the vector fetch logic, under control of the program run, freeze and abort bits, and keeps an issued-address count for status readback.

---
 rtl/addr_fifo_reader_if.sv | 30 +++
 rtl/addr_fifo_reader.sv | 145 ++++++++++++++
 tb/tb_addr_fifo_reader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addr_fifo_reader_if.sv
// FIFO read port plus the address stream toward the vector fetch logic.
// The master side is the FIFO reader; the slave side is the FIFO and downstream consumer.
interface addr_fifo_reader_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  addr_fifo_empty;
   logic [ADDR_WIDTH-1:0] addr_fifo_dout;
   logic                  addr_fifo_rd;
   logic [ADDR_WIDTH-1:0] vctr_addr;
   logic                  vctr_addr_valid;
   logic                  vctr_addr_ready;

   modport master (
      input  addr_fifo_empty,
      input  addr_fifo_dout,
      input  vctr_addr_ready,
      output addr_fifo_rd,
      output vctr_addr,
      output vctr_addr_valid
   );

   modport slave (
      output addr_fifo_empty,
      output addr_fifo_dout,
      output vctr_addr_ready,
      input  addr_fifo_rd,
      input  vctr_addr,
      input  vctr_addr_valid
   );
endinterface

// File: rtl/addr_fifo_reader.sv
// Pops host-written address words and emits one address, or a stride-spaced burst,
// per word on a valid/ready stream; keeps pop and issue counters for status readback.
module addr_fifo_reader #(
   parameter int ADDR_WIDTH   = 32,
   parameter int CONSEC_WIDTH = 8,
   parameter int ADDR_STRIDE  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    active_program,
   input  logic                    abort_program,
   input  logic                    freeze_addr_fifo,
   input  logic                    send_consec_addr,
   input  logic [CONSEC_WIDTH-1:0] consec_count,
   addr_fifo_reader_if.master      bus,
   output logic [15:0]             words_popped,
   output logic [15:0]             addrs_issued,
   output logic                    busy
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SEND
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [CONSEC_WIDTH-1:0] remaining_q, remaining_d;
   logic                    valid_q, valid_d;
   logic                    rd_q, rd_d;
   logic                    busy_q, busy_d;
   logic [15:0]             words_q, words_d;
   logic [15:0]             issued_q, issued_d;
   logic                    active_prev_q;

   logic handshake;
   logic pop_ok;
   logic program_rise;

   assign handshake    = valid_q & bus.vctr_addr_ready;
   assign pop_ok       = active_program & ~freeze_addr_fifo & ~abort_program & ~bus.addr_fifo_empty;
   assign program_rise = active_program & ~active_prev_q;

   // The pop strobe is registered, so a pop is decided one cycle before rd is seen.
   // IDLE with rd_q high is the pop cycle itself; FETCH follows and captures dout.
   always_comb begin
      // NOTE: every next-state signal takes its hold value first so no path infers a latch.
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      valid_d     = valid_q;
      rd_d        = 1'b0;

      if (abort_program) begin
         state_d     = IDLE;
         valid_d     = 1'b0;
         remaining_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rd_q) begin
                  state_d = FETCH;
               end else if (pop_ok) begin
                  rd_d = 1'b1;
               end
            end
            FETCH: begin
               addr_d      = bus.addr_fifo_dout;
               remaining_d = send_consec_addr ? consec_count : '0;
               valid_d     = 1'b1;
               state_d     = SEND;
            end
            SEND: begin
               if (handshake) begin
                  if (remaining_q == '0) begin
                     state_d = IDLE;
                     valid_d = 1'b0;
                     rd_d    = pop_ok;
                  end else begin
                     addr_d      = addr_q + STRIDE;
                     remaining_d = remaining_q - 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         endcase
      end

      busy_d = (state_d != IDLE);

      // A program start clears both counters and wins over a same-cycle increment.
      words_d  = words_q;
      issued_d = issued_q;
      if (program_rise) begin
         words_d  = '0;
         issued_d = '0;
      end else begin
         if (rd_q) begin
            words_d = words_q + 16'd1;
         end
         if (handshake && (issued_q != 16'hFFFF)) begin
            issued_d = issued_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (reset) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         remaining_q   <= '0;
         valid_q       <= 1'b0;
         rd_q          <= 1'b0;
         busy_q        <= 1'b0;
         words_q       <= '0;
         issued_q      <= '0;
         active_prev_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         remaining_q   <= remaining_d;
         valid_q       <= valid_d;
         rd_q          <= rd_d;
         busy_q        <= busy_d;
         words_q       <= words_d;
         issued_q      <= issued_d;
         active_prev_q <= active_program;
      end
   end

   assign bus.addr_fifo_rd    = rd_q;
   assign bus.vctr_addr       = addr_q;
   assign bus.vctr_addr_valid = valid_q;
   assign words_popped        = words_q;
   assign addrs_issued        = issued_q;
   assign busy                = busy_q;

endmodule

// File: tb/tb_addr_fifo_reader.sv
// Directed bench for addr_fifo_reader: a small FIFO model feeds words, a negedge
// monitor logs pops and handshakes, and hand-computed expectations are checked.
module tb_addr_fifo_reader;
   localparam int AW = 32;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          active_program;
   logic          abort_program;
   logic          freeze_addr_fifo;
   logic          send_consec_addr;
   logic [CW-1:0] consec_count;
   logic [15:0]   words_popped;
   logic [15:0]   addrs_issued;
   logic          busy;

   addr_fifo_reader_if #(.ADDR_WIDTH(AW)) bus ();

   addr_fifo_reader #(
      .ADDR_WIDTH  (AW),
      .CONSEC_WIDTH(CW),
      .ADDR_STRIDE (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .active_program  (active_program),
      .abort_program   (abort_program),
      .freeze_addr_fifo(freeze_addr_fifo),
      .send_consec_addr(send_consec_addr),
      .consec_count    (consec_count),
      .bus             (bus.master),
      .words_popped    (words_popped),
      .addrs_issued    (addrs_issued),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   // FIFO model: data appears on dout the cycle after the pop strobe.
   logic [AW-1:0] mem [0:63];
   int pushed = 0;
   int popped = 0;
   assign bus.addr_fifo_empty = (pushed == popped);

   always @(posedge clk) begin
      if (bus.addr_fifo_rd && (pushed != popped)) begin
         bus.addr_fifo_dout <= mem[popped];
         popped             <= popped + 1;
      end
   end

   // Monitor samples on the falling edge, half a cycle from the active edge.
   int            cyc = 0;
   int            rd_cnt = 0;
   int            bad_rd = 0;
   int            valid_cyc = 0;
   int            unstable = 0;
   int            last_rd_cyc = 0;
   int            valid_rise_cyc = 0;
   logic          prev_valid = 1'b0;
   logic          prev_ready = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [AW-1:0] hs_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.addr_fifo_rd) begin
         rd_cnt      <= rd_cnt + 1;
         last_rd_cyc <= cyc;
         if (bus.addr_fifo_empty) bad_rd <= bad_rd + 1;
      end
      if (bus.vctr_addr_valid) begin
         valid_cyc <= valid_cyc + 1;
         if (!prev_valid) valid_rise_cyc <= cyc;
         if (bus.vctr_addr_ready) hs_q.push_back(bus.vctr_addr);
      end
      if (prev_valid && !prev_ready &&
          (!bus.vctr_addr_valid || (bus.vctr_addr != prev_addr))) begin
         unstable <= unstable + 1;
      end
      prev_valid <= bus.vctr_addr_valid;
      prev_ready <= bus.vctr_addr_ready;
      prev_addr  <= bus.vctr_addr;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] w);
      mem[pushed] = w;
      pushed++;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (n < 300 && !(pushed == popped && !busy && !bus.vctr_addr_valid && !bus.addr_fifo_rd)) begin
         tick();
         n++;
      end
      check(tag, 32'(n < 300), 32'd1);
      tick();
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (n < 50 && !bus.vctr_addr_valid) begin
         tick();
         n++;
      end
      check(tag, 32'(n < 50), 32'd1);
   endtask

   task automatic check_burst(input string tag, input int h0, input logic [AW-1:0] base, input int len);
      check({tag, "_hs_count"}, 32'(hs_q.size() - h0), 32'(len));
      for (int i = 0; i < len; i++) begin
         check($sformatf("%s_addr%0d", tag, i), hs_q[h0 + i], base + AW'(4 * i));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int r0, h0, v0, u0;
   int pat [7] = '{1, 0, 0, 1, 0, 1, 1};

   initial begin
      reset                = 1'b1;
      active_program       = 1'b1;
      abort_program        = 1'b0;
      freeze_addr_fifo     = 1'b0;
      send_consec_addr     = 1'b0;
      consec_count         = '0;
      bus.vctr_addr_ready  = 1'b1;
      repeat (3) tick();

      check("rst_rd", 32'(bus.addr_fifo_rd), 32'd0);
      check("rst_addr", bus.vctr_addr, 32'h0);
      check("rst_valid", 32'(bus.vctr_addr_valid), 32'd0);
      check("rst_words", 32'(words_popped), 32'd0);
      check("rst_issued", 32'(addrs_issued), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      repeat (2) tick();

      // Single word
      r0 = rd_cnt; h0 = hs_q.size(); v0 = valid_cyc;
      push(32'h0000_1000);
      drain("t1_drain");
      check("t1_rd_pulses", 32'(rd_cnt - r0), 32'd1);
      check_burst("t1", h0, 32'h1000, 1);
      check("t1_valid_cycles", 32'(valid_cyc - v0), 32'd1);
      check("t1_latency", 32'(valid_rise_cyc - last_rd_cyc), 32'd2);
      check("t1_words", 32'(words_popped), 32'd1);
      check("t1_issued", 32'(addrs_issued), 32'd1);

      // Burst of 4; mode inputs change mid-burst and must not matter
      send_consec_addr = 1'b1;
      consec_count     = 8'd3;
      r0 = rd_cnt; h0 = hs_q.size(); v0 = valid_cyc;
      push(32'h0000_0100);
      wait_valid("t2_wait");
      consec_count     = 8'd9;
      send_consec_addr = 1'b0;
      drain("t2_drain");
      check_burst("t2", h0, 32'h100, 4);
      check("t2_rd_pulses", 32'(rd_cnt - r0), 32'd1);
      check("t2_valid_cycles", 32'(valid_cyc - v0), 32'd4);
      check("t2_words", 32'(words_popped), 32'd2);
      check("t2_issued", 32'(addrs_issued), 32'd5);

      // Backpressure
      send_consec_addr = 1'b1;
      consec_count     = 8'd3;
      r0 = rd_cnt; h0 = hs_q.size(); v0 = valid_cyc; u0 = unstable;
      push(32'h0000_0100);
      wait_valid("t3_wait");
      for (int i = 0; i < 7; i++) begin
         bus.vctr_addr_ready = pat[i][0];
         tick();
      end
      check("t3_valid_drop", 32'(bus.vctr_addr_valid), 32'd0);
      bus.vctr_addr_ready = 1'b1;
      drain("t3_drain");
      check_burst("t3", h0, 32'h100, 4);
      check("t3_unstable", 32'(unstable - u0), 32'd0);
      check("t3_valid_cycles", 32'(valid_cyc - v0), 32'd7);
      check("t3_rd_pulses", 32'(rd_cnt - r0), 32'd1);
      check("t3_issued", 32'(addrs_issued), 32'd9);

      // Address wrap
      consec_count = 8'd2;
      h0 = hs_q.size();
      push(32'hFFFF_FFF8);
      drain("t4_drain");
      check_burst("t4", h0, 32'hFFFF_FFF8, 3);
      check("t4_words", 32'(words_popped), 32'd4);
      check("t4_issued", 32'(addrs_issued), 32'd12);

      // Abort on the second address of a 4-address burst
      consec_count = 8'd3;
      h0 = hs_q.size(); r0 = rd_cnt;
      push(32'h0000_2000);
      wait_valid("t5_wait");
      begin
         int n = 0;
         while (bus.vctr_addr != 32'h2004 && n < 10) begin
            tick();
            n++;
         end
      end
      check("t5_second_addr", bus.vctr_addr, 32'h2004);
      abort_program = 1'b1;
      tick();
      check("t5_valid_after_abort", 32'(bus.vctr_addr_valid), 32'd0);
      check("t5_busy_after_abort", 32'(busy), 32'd0);
      abort_program = 1'b0;
      repeat (5) tick();
      check_burst("t5", h0, 32'h2000, 2);
      check("t5_rd_pulses", 32'(rd_cnt - r0), 32'd1);
      check("t5_words", 32'(words_popped), 32'd5);
      check("t5_issued", 32'(addrs_issued), 32'd14);

      // Freeze holds off pops; release pops on the next cycle
      send_consec_addr = 1'b0;
      freeze_addr_fifo = 1'b1;
      r0 = rd_cnt; h0 = hs_q.size();
      push(32'h0000_3000);
      repeat (20) tick();
      check("t6_frozen_rd", 32'(rd_cnt - r0), 32'd0);
      freeze_addr_fifo = 1'b0;
      tick();
      check("t6_release_rd", 32'(bus.addr_fifo_rd), 32'd1);
      drain("t6_drain");
      check_burst("t6", h0, 32'h3000, 1);
      check("t6_issued", 32'(addrs_issued), 32'd15);

      // Counter clear on program start
      for (int i = 0; i < 5; i++) push(32'h0000_5000 + 32'(16 * i));
      drain("t7_drain5");
      check("t7_words_pre", 32'(words_popped), 32'd11);
      check("t7_issued_pre", 32'(addrs_issued), 32'd20);
      active_program = 1'b0;
      r0 = rd_cnt;
      repeat (2) tick();
      push(32'h0000_6000);
      push(32'h0000_6004);
      tick();
      check("t7_inactive_rd", 32'(rd_cnt - r0), 32'd0);
      active_program = 1'b1;
      tick();
      check("t7_words_clear", 32'(words_popped), 32'd0);
      check("t7_issued_clear", 32'(addrs_issued), 32'd0);
      drain("t7_drain2");
      check("t7_words_post", 32'(words_popped), 32'd2);
      check("t7_issued_post", 32'(addrs_issued), 32'd2);

      // Reset mid-burst
      send_consec_addr = 1'b1;
      consec_count     = 8'd3;
      push(32'h0000_4000);
      wait_valid("t8_wait");
      tick();
      reset = 1'b1;
      tick();
      check("t8_valid", 32'(bus.vctr_addr_valid), 32'd0);
      check("t8_addr", bus.vctr_addr, 32'h0);
      check("t8_words", 32'(words_popped), 32'd0);
      check("t8_issued", 32'(addrs_issued), 32'd0);
      check("t8_busy", 32'(busy), 32'd0);
      check("t8_rd", 32'(bus.addr_fifo_rd), 32'd0);
      reset = 1'b0;
      h0 = hs_q.size();
      repeat (4) tick();
      check("t8_no_more_addrs", 32'(hs_q.size() - h0), 32'd0);

      check("rd_while_empty", 32'(bad_rd), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
